// File: rtl/alu_sequencer.sv
// Sequencing controller for the 16-bit logic unit and its fixed-latency divider.
// Accepts one opcode at a time and drives the logic unit's operation and result-push strobes.
module alu_sequencer #(
   parameter int DIV_LATENCY = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       op_valid,
   input  logic [3:0] op_code,
   output logic       op_ready,
   output logic       hold_operands,
   output logic       done,
   output logic       err,
   output logic       add,
   output logic       sub,
   output logic       inc,
   output logic       dec,
   output logic       mul,
   output logic       shr,
   output logic       shl,
   output logic       band,
   output logic       bor,
   output logic       bxor,
   output logic       bnegate,
   output logic       push,
   output logic       push_high,
   output logic       push_div,
   output logic       push_mod
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXEC,
      S_PUSH,
      S_DIV_WAIT,
      S_PUSH_Q,
      S_PUSH_R,
      S_ERR
   } state_t;

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_SUB    = 4'd1;
   localparam logic [3:0] OP_INC    = 4'd2;
   localparam logic [3:0] OP_DEC    = 4'd3;
   localparam logic [3:0] OP_MUL    = 4'd4;
   localparam logic [3:0] OP_SHR    = 4'd5;
   localparam logic [3:0] OP_SHL    = 4'd6;
   localparam logic [3:0] OP_AND    = 4'd7;
   localparam logic [3:0] OP_OR     = 4'd8;
   localparam logic [3:0] OP_XOR    = 4'd9;
   localparam logic [3:0] OP_NOT    = 4'd10;
   localparam logic [3:0] OP_MOD    = 4'd12;
   localparam logic [3:0] OP_DIVMOD = 4'd13;

   localparam logic [7:0] DIV_LOAD = 8'(DIV_LATENCY - 1);

   state_t     state_q, state_d;
   logic [3:0] op_q, op_d;
   logic [7:0] count_q, count_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= 4'd0;
         count_q <= 8'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         count_q <= count_d;
      end
   end

   // Opcode is captured only at acceptance; op_valid outside IDLE is ignored.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      count_d = count_q;
      case (state_q)
         S_IDLE: begin
            if (op_valid) begin
               op_d = op_code;
               if (op_code <= OP_NOT) begin
                  state_d = S_EXEC;
               end else if (op_code <= OP_DIVMOD) begin
                  state_d = S_DIV_WAIT;
                  count_d = DIV_LOAD;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
         S_EXEC:     state_d = S_PUSH;
         S_PUSH:     state_d = S_IDLE;
         S_DIV_WAIT: begin
            if (count_q == 8'd0) begin
               state_d = (op_q == OP_MOD) ? S_PUSH_R : S_PUSH_Q;
            end else begin
               count_d = count_q - 8'd1;
            end
         end
         S_PUSH_Q:   state_d = (op_q == OP_DIVMOD) ? S_PUSH_R : S_IDLE;
         S_PUSH_R:   state_d = S_IDLE;
         S_ERR:      state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_comb begin
      op_ready      = 1'b0;
      hold_operands = 1'b0;
      done          = 1'b0;
      err           = 1'b0;
      add           = 1'b0;
      sub           = 1'b0;
      inc           = 1'b0;
      dec           = 1'b0;
      mul           = 1'b0;
      shr           = 1'b0;
      shl           = 1'b0;
      band          = 1'b0;
      bor           = 1'b0;
      bxor          = 1'b0;
      bnegate       = 1'b0;
      push          = 1'b0;
      push_high     = 1'b0;
      push_div      = 1'b0;
      push_mod      = 1'b0;
      case (state_q)
         S_IDLE: op_ready = 1'b1;
         S_EXEC: begin
            hold_operands = 1'b1;
            case (op_q)
               OP_ADD:  add     = 1'b1;
               OP_SUB:  sub     = 1'b1;
               OP_INC:  inc     = 1'b1;
               OP_DEC:  dec     = 1'b1;
               OP_MUL:  mul     = 1'b1;
               OP_SHR:  shr     = 1'b1;
               OP_SHL:  shl     = 1'b1;
               OP_AND:  band    = 1'b1;
               OP_OR:   bor     = 1'b1;
               OP_XOR:  bxor    = 1'b1;
               OP_NOT:  bnegate = 1'b1;
               default: ;
            endcase
         end
         S_PUSH: begin
            push      = 1'b1;
            push_high = 1'b1;
            done      = 1'b1;
         end
         S_DIV_WAIT: hold_operands = 1'b1;
         S_PUSH_Q: begin
            hold_operands = 1'b1;
            push_div      = 1'b1;
            done          = (op_q != OP_DIVMOD);
         end
         S_PUSH_R: begin
            hold_operands = 1'b1;
            push_mod      = 1'b1;
            done          = 1'b1;
         end
         S_ERR:   err = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed-vector bench for alu_sequencer: default latency instance plus a DIV_LATENCY=1 instance.
// Each observation packs {op_ready, hold, done, err, push[3:0], strobes[10:0]}.
module tb_alu_sequencer;

   logic       clk;
   logic       rst;
   logic       op_valid;
   logic [3:0] op_code;

   logic       op_ready_a, hold_a, done_a, err_a;
   logic       add_a, sub_a, inc_a, dec_a, mul_a, shr_a, shl_a, band_a, bor_a, bxor_a, bneg_a;
   logic       push_a, push_high_a, push_div_a, push_mod_a;

   logic       op_ready_b, hold_b, done_b, err_b;
   logic       add_b, sub_b, inc_b, dec_b, mul_b, shr_b, shl_b, band_b, bor_b, bxor_b, bneg_b;
   logic       push_b, push_high_b, push_div_b, push_mod_b;

   int checks;
   int errors;

   localparam logic [10:0] ST_NONE = 11'b000_0000_0000;
   localparam logic [10:0] ST_ADD  = 11'b100_0000_0000;
   localparam logic [10:0] ST_AND  = 11'b000_0000_1000;
   localparam logic [10:0] ST_NOT  = 11'b000_0000_0001;
   localparam logic [10:0] ST_SUB  = 11'b010_0000_0000;

   localparam logic [3:0] P_NONE = 4'b0000;
   localparam logic [3:0] P_MAIN = 4'b1100;
   localparam logic [3:0] P_DIV  = 4'b0010;
   localparam logic [3:0] P_MOD  = 4'b0001;

   alu_sequencer #(.DIV_LATENCY(20)) dut (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
      .op_ready(op_ready_a), .hold_operands(hold_a), .done(done_a), .err(err_a),
      .add(add_a), .sub(sub_a), .inc(inc_a), .dec(dec_a), .mul(mul_a),
      .shr(shr_a), .shl(shl_a), .band(band_a), .bor(bor_a), .bxor(bxor_a),
      .bnegate(bneg_a), .push(push_a), .push_high(push_high_a),
      .push_div(push_div_a), .push_mod(push_mod_a)
   );

   alu_sequencer #(.DIV_LATENCY(1)) dut_lat1 (
      .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
      .op_ready(op_ready_b), .hold_operands(hold_b), .done(done_b), .err(err_b),
      .add(add_b), .sub(sub_b), .inc(inc_b), .dec(dec_b), .mul(mul_b),
      .shr(shr_b), .shl(shl_b), .band(band_b), .bor(bor_b), .bxor(bxor_b),
      .bnegate(bneg_b), .push(push_b), .push_high(push_high_b),
      .push_div(push_div_b), .push_mod(push_mod_b)
   );

   logic [18:0] obs_a, obs_b;
   assign obs_a = {op_ready_a, hold_a, done_a, err_a,
                   push_a, push_high_a, push_div_a, push_mod_a,
                   add_a, sub_a, inc_a, dec_a, mul_a, shr_a, shl_a,
                   band_a, bor_a, bxor_a, bneg_a};
   assign obs_b = {op_ready_b, hold_b, done_b, err_b,
                   push_b, push_high_b, push_div_b, push_mod_b,
                   add_b, sub_b, inc_b, dec_b, mul_b, shr_b, shl_b,
                   band_b, bor_b, bxor_b, bneg_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [18:0] ev(input logic r, input logic h, input logic d,
                                      input logic e, input logic [3:0] p,
                                      input logic [10:0] s);
      return {r, h, d, e, p, s};
   endfunction

   task automatic checkOutput(input string tag, input logic [18:0] got, input logic [18:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b required %b at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one cycle and settle just after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] code);
      op_valid = v;
      op_code  = code;
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      op_valid = 1'b0;
      op_code  = 4'd0;
      step();
      step();
      checkOutput("reset_state", obs_a, ev(1, 0, 0, 0, P_NONE, ST_NONE));

      // rst wins over a simultaneous request
      applyStimulus(1'b1, 4'd0);
      step();
      checkOutput("reset_priority", obs_a, ev(1, 0, 0, 0, P_NONE, ST_NONE));
      rst = 1'b0;

      // ADD accepted at next edge
      step();
      applyStimulus(1'b0, 4'd0);
      checkOutput("add_exec", obs_a, ev(0, 1, 0, 0, P_NONE, ST_ADD));
      step();
      checkOutput("add_push", obs_a, ev(0, 0, 1, 0, P_MAIN, ST_NONE));
      step();
      checkOutput("add_ready_again", obs_a, ev(1, 0, 0, 0, P_NONE, ST_NONE));

      // Back-to-back AND then NOT with op_valid held high
      applyStimulus(1'b1, 4'd7);
      step();
      applyStimulus(1'b1, 4'd10);
      checkOutput("and_exec_regd_opcode", obs_a, ev(0, 1, 0, 0, P_NONE, ST_AND));
      step();
      checkOutput("and_push", obs_a, ev(0, 0, 1, 0, P_MAIN, ST_NONE));
      step();
      checkOutput("b2b_ready", obs_a, ev(1, 0, 0, 0, P_NONE, ST_NONE));
      step();
      applyStimulus(1'b0, 4'd0);
      checkOutput("not_exec", obs_a, ev(0, 1, 0, 0, P_NONE, ST_NOT));
      step();
      checkOutput("not_push", obs_a, ev(0, 0, 1, 0, P_MAIN, ST_NONE));
      step();
      checkOutput("not_idle", obs_a, ev(1, 0, 0, 0, P_NONE, ST_NONE));

      // DIVMOD with latency 20
      applyStimulus(1'b1, 4'd13);
      step();
      applyStimulus(1'b0, 4'd0);
      for (int k = 1; k <= 20; k++) begin
         checkOutput($sformatf("divmod_wait_%0d", k), obs_a, ev(0, 1, 0, 0, P_NONE, ST_NONE));
         step();
      end
      checkOutput("divmod_push_q", obs_a, ev(0, 1, 0, 0, P_DIV, ST_NONE));
      step();
      checkOutput("divmod_push_r", obs_a, ev(0, 1, 1, 0, P_MOD, ST_NONE));
      step();
      checkOutput("divmod_idle", obs_a, ev(1, 0, 0, 0, P_NONE, ST_NONE));

      // Illegal opcodes 15 and 14
      applyStimulus(1'b1, 4'd15);
      step();
      applyStimulus(1'b0, 4'd0);
      checkOutput("err15_pulse", obs_a, ev(0, 0, 0, 1, P_NONE, ST_NONE));
      step();
      checkOutput("err15_ready", obs_a, ev(1, 0, 0, 0, P_NONE, ST_NONE));
      applyStimulus(1'b1, 4'd14);
      step();
      applyStimulus(1'b0, 4'd0);
      checkOutput("err14_pulse", obs_a, ev(0, 0, 0, 1, P_NONE, ST_NONE));
      step();
      checkOutput("err14_ready", obs_a, ev(1, 0, 0, 0, P_NONE, ST_NONE));

      // DIV with an ADD request held during the wait
      applyStimulus(1'b1, 4'd11);
      step();
      applyStimulus(1'b1, 4'd0);
      for (int k = 1; k <= 20; k++) begin
         checkOutput($sformatf("div_ignore_%0d", k), obs_a, ev(0, 1, 0, 0, P_NONE, ST_NONE));
         step();
      end
      applyStimulus(1'b0, 4'd0);
      checkOutput("div_push_q", obs_a, ev(0, 1, 1, 0, P_DIV, ST_NONE));
      step();
      checkOutput("div_idle", obs_a, ev(1, 0, 0, 0, P_NONE, ST_NONE));
      step();
      checkOutput("div_no_extra", obs_a, ev(1, 0, 0, 0, P_NONE, ST_NONE));

      // Reset in the 5th DIV_WAIT cycle
      applyStimulus(1'b1, 4'd11);
      step();
      applyStimulus(1'b0, 4'd0);
      for (int k = 1; k <= 4; k++) begin
         checkOutput($sformatf("rstdiv_wait_%0d", k), obs_a, ev(0, 1, 0, 0, P_NONE, ST_NONE));
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("rstdiv_idle", obs_a, ev(1, 0, 0, 0, P_NONE, ST_NONE));
      for (int k = 0; k < 24; k++) begin
         step();
         checkOutput($sformatf("rstdiv_quiet_%0d", k), obs_a, ev(1, 0, 0, 0, P_NONE, ST_NONE));
      end

      // Minimum latency instance: DIV then MOD
      applyStimulus(1'b1, 4'd11);
      step();
      applyStimulus(1'b0, 4'd0);
      checkOutput("lat1_div_wait", obs_b, ev(0, 1, 0, 0, P_NONE, ST_NONE));
      step();
      checkOutput("lat1_div_push", obs_b, ev(0, 1, 1, 0, P_DIV, ST_NONE));
      step();
      checkOutput("lat1_div_idle", obs_b, ev(1, 0, 0, 0, P_NONE, ST_NONE));
      applyStimulus(1'b1, 4'd12);
      step();
      applyStimulus(1'b0, 4'd0);
      checkOutput("lat1_mod_wait", obs_b, ev(0, 1, 0, 0, P_NONE, ST_NONE));
      step();
      checkOutput("lat1_mod_push", obs_b, ev(0, 1, 1, 0, P_MOD, ST_NONE));
      step();
      checkOutput("lat1_mod_idle", obs_b, ev(1, 0, 0, 0, P_NONE, ST_NONE));

      // SUB on the minimum latency instance
      applyStimulus(1'b1, 4'd1);
      step();
      applyStimulus(1'b0, 4'd0);
      checkOutput("lat1_sub_exec", obs_b, ev(0, 1, 0, 0, P_NONE, ST_SUB));
      step();
      checkOutput("lat1_sub_push", obs_b, ev(0, 0, 1, 0, P_MAIN, ST_NONE));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
